// File: rtl/msync_pkg.sv
// Shared definitions for the master sync generator: trigger modes, FSM states, timing defaults.
package msync_pkg;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_TIMER = 2'b01;
  localparam logic [1:0] MODE_WHEEL = 2'b10;
  localparam logic [1:0] MODE_EXT   = 2'b11;

  localparam int unsigned PULSE_CYCLES_DEF = 10;
  localparam int unsigned MIN_GAP_DEF      = 100;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

endpackage

// File: rtl/msync_gen_quad_dec.sv
// Input conditioning and 4x quadrature decoder for the wheel encoder, plus sync edge detect.
// Optional glitch filter after the synchronizers: MSYNC_GEN_GLITCH_FILTER_EN.
module quad_dec #(
`ifdef MSYNC_GEN_GLITCH_FILTER_EN
  parameter int unsigned FILT_LEN = 4
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adp,
  input  logic        bdp,
  input  logic        sync,
  output logic        step_fwd,
  output logic        step_bwd,
  output logic        illegal,
  output logic        sync_rise,
  output logic [31:0] pos
);

  localparam int unsigned NSIG = 3;

  // Bit order throughout: [2]=A, [1]=B, [0]=sync
  logic [NSIG-1:0] raw;
  logic [NSIG-1:0] meta;
  logic [NSIG-1:0] synced;
  logic [NSIG-1:0] cur;
  logic [NSIG-1:0] prev;
  logic [1:0]      ab_prev;
  logic [1:0]      ab_cur;

  assign raw = {adp, bdp, sync};

  // Two-stage synchronizer for the asynchronous pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= '0;
      synced <= '0;
    end else begin
      meta   <= raw;
      synced <= meta;
    end
  end

`ifdef MSYNC_GEN_GLITCH_FILTER_EN
  localparam int unsigned FCNT_W = $clog2(FILT_LEN + 1);

  logic [NSIG-1:0]   filt;
  logic [FCNT_W-1:0] fcnt [NSIG];

  // Filtered value follows the synchronized value only after FILT_LEN stable cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= '0;
      for (int i = 0; i < int'(NSIG); i++) fcnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NSIG); i++) begin
        if (synced[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FCNT_W'(FILT_LEN - 1)) begin
          filt[i] <= synced[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FCNT_W'(1);
        end
      end
    end
  end

  assign cur = filt;
`else
  assign cur = synced;
`endif

  // Previous conditioned value for edge / transition detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= '0;
    else        prev <= cur;
  end

  assign ab_prev   = prev[2:1];
  assign ab_cur    = cur[2:1];
  assign sync_rise = cur[0] & ~prev[0];
  assign illegal   = &(ab_prev ^ ab_cur);

  // Forward is AB 00->01->11->10->00, backward the reverse
  always_comb begin
    step_fwd = 1'b0;
    step_bwd = 1'b0;
    case ({ab_prev, ab_cur})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: step_fwd = 1'b1;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: step_bwd = 1'b1;
      default: ;
    endcase
  end

  // Signed wheel position, wraps at 32 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        pos <= '0;
    else if (step_fwd) pos <= pos + 32'd1;
    else if (step_bwd) pos <= pos - 32'd1;
  end

endmodule

// File: rtl/msync_gen.sv
// Master sync pulse generator: timer, wheel or external trigger -> fixed-width active-low pulse
// with enforced hold-off. Optional input glitch filter: MSYNC_GEN_GLITCH_FILTER_EN.
module msync_gen
  import msync_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = PULSE_CYCLES_DEF,
  parameter int unsigned MIN_GAP      = MIN_GAP_DEF
`ifdef MSYNC_GEN_GLITCH_FILTER_EN
  , parameter int unsigned FILT_LEN   = 4
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  i_mode,
  input  logic [23:0] i_period,
  input  logic [7:0]  i_wheel_div,
  input  logic        i_adp,
  input  logic        i_bdp,
  input  logic        i_sync,
  input  logic        i_err_clr,
  output logic        o_msync_n,
  output logic [31:0] o_wheel_pos,
  output logic        o_dir,
  output logic [15:0] o_sync_cnt,
  output logic        o_quad_err,
  output logic        o_overrun
);

  localparam int unsigned CNT_MAX = (MIN_GAP > PULSE_CYCLES) ? MIN_GAP : PULSE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned ACC_W   = 9;

  logic                    step_fwd;
  logic                    step_bwd;
  logic                    illegal;
  logic                    sync_rise;
  logic [1:0]              mode_q;
  logic                    mode_chg;
  logic [23:0]             tcnt;
  logic                    tcnt_wrap;
  logic                    timer_hit;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_inc;
  logic signed [ACC_W-1:0] div_s;
  logic [7:0]              div_eff;
  logic                    wheel_hit;
  logic                    trig;
  logic                    drop;
  state_t                  state;
  state_t                  state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_nxt;
  logic [15:0]             sync_cnt_nxt;
  logic                    msync_n_nxt;

  quad_dec
`ifdef MSYNC_GEN_GLITCH_FILTER_EN
    #(.FILT_LEN(FILT_LEN))
`endif
  u_quad_dec (
    .clk       (clk),
    .rst_n     (rst_n),
    .adp       (i_adp),
    .bdp       (i_bdp),
    .sync      (i_sync),
    .step_fwd  (step_fwd),
    .step_bwd  (step_bwd),
    .illegal   (illegal),
    .sync_rise (sync_rise),
    .pos       (o_wheel_pos)
  );

  assign mode_chg  = (i_mode != mode_q);
  assign tcnt_wrap = (i_period != 24'd0) && (tcnt >= i_period - 24'd1);
  assign timer_hit = !mode_chg && tcnt_wrap;
  assign div_eff   = (i_wheel_div == 8'd0) ? 8'd1 : i_wheel_div;
  assign div_s     = $signed({1'b0, div_eff});
  assign acc_inc   = acc + 9'sd1;
  assign wheel_hit = step_fwd && (acc_inc >= div_s);

  // Trigger source selection
  always_comb begin
    trig = 1'b0;
    case (i_mode)
      MODE_OFF:   trig = 1'b0;
      MODE_TIMER: trig = timer_hit;
      MODE_WHEEL: trig = wheel_hit;
      MODE_EXT:   trig = sync_rise;
      default:    trig = 1'b0;
    endcase
  end

  assign drop = trig && (state != IDLE);

  // Period timer and wheel accumulator; both restart on a mode change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_OFF;
      tcnt   <= '0;
      acc    <= '0;
    end else begin
      mode_q <= i_mode;
      if (mode_chg)
        tcnt <= '0;
      else if (i_mode == MODE_TIMER && i_period != 24'd0)
        tcnt <= tcnt_wrap ? 24'd0 : tcnt + 24'd1;
      if (mode_chg) begin
        acc <= '0;
      end else if (i_mode == MODE_WHEEL) begin
        if (step_fwd)
          acc <= wheel_hit ? 9'sd0 : acc_inc;
        else if (step_bwd && acc != -9'sd255)
          acc <= acc - 9'sd1;
      end
    end
  end

  // Pulse FSM state and registered pulse outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      o_sync_cnt <= '0;
      o_msync_n  <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      o_sync_cnt <= sync_cnt_nxt;
      o_msync_n  <= msync_n_nxt;
    end
  end

  // Pulse FSM next state: IDLE -> PULSE (low) -> HOLDOFF (high) -> IDLE
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    sync_cnt_nxt = o_sync_cnt;
    case (state)
      IDLE: begin
        if (trig) begin
          state_nxt    = PULSE;
          cnt_nxt      = '0;
          sync_cnt_nxt = o_sync_cnt + 16'd1;
        end
      end
      PULSE: begin
        if (cnt == CNT_W'(PULSE_CYCLES - 1)) begin
          state_nxt = HOLDOFF;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HOLDOFF: begin
        if (cnt == CNT_W'(MIN_GAP - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    msync_n_nxt = (state_nxt != PULSE);
  end

  // Direction and sticky error flags; a new event beats a clear in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_dir      <= 1'b1;
      o_quad_err <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      if (step_fwd)      o_dir <= 1'b1;
      else if (step_bwd) o_dir <= 1'b0;
      if (illegal)        o_quad_err <= 1'b1;
      else if (i_err_clr) o_quad_err <= 1'b0;
      if (drop)           o_overrun <= 1'b1;
      else if (i_err_clr) o_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_msync_gen.sv
// Self-checking bench for msync_gen: per-cycle reference model plus directed literal checks.
module tb_msync_gen;

  localparam int PW  = 10;
  localparam int GAP = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  i_mode = 2'b00;
  logic [23:0] i_period = '0;
  logic [7:0]  i_wheel_div = '0;
  logic        i_adp = 1'b0;
  logic        i_bdp = 1'b0;
  logic        i_sync = 1'b0;
  logic        i_err_clr = 1'b0;
  logic        o_msync_n;
  logic [31:0] o_wheel_pos;
  logic        o_dir;
  logic [15:0] o_sync_cnt;
  logic        o_quad_err;
  logic        o_overrun;

  always #5 clk = ~clk;

  msync_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_mode      (i_mode),
    .i_period    (i_period),
    .i_wheel_div (i_wheel_div),
    .i_adp       (i_adp),
    .i_bdp       (i_bdp),
    .i_sync      (i_sync),
    .i_err_clr   (i_err_clr),
    .o_msync_n   (o_msync_n),
    .o_wheel_pos (o_wheel_pos),
    .o_dir       (o_dir),
    .o_sync_cnt  (o_sync_cnt),
    .o_quad_err  (o_quad_err),
    .o_overrun   (o_overrun)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Gray index of an AB pair along the forward sequence 00,01,11,10
  function automatic int gidx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Reference model state (expected outputs describe the current cycle)
  int          cyc    = 0;
  int          m_last = -1000;
  int          m_tcnt = 0;
  int          m_acc  = 0;
  logic [2:0]  q1 = '0, q2 = '0, q3 = '0;
  logic [1:0]  m_mode_q = 2'b00;
  logic        e_msync_n = 1'b1, e_dir = 1'b1, e_qerr = 1'b0, e_ovr = 1'b0;
  logic [31:0] e_pos = '0;
  logic [15:0] e_cnt = '0;

  always @(negedge clk) begin
    int  d, div;
    logic fwd, bwd, ill, srise, chg, trig, busy;
    cyc++;
    if (!rst_n) begin
      m_last = -1000; m_tcnt = 0; m_acc = 0;
      q1 = '0; q2 = '0; q3 = '0; m_mode_q = 2'b00;
      e_msync_n = 1'b1; e_dir = 1'b1; e_qerr = 1'b0; e_ovr = 1'b0;
      e_pos = '0; e_cnt = '0;
    end
    check("msync_n", 32'(o_msync_n), 32'(e_msync_n));
    check("wheel_pos", o_wheel_pos, e_pos);
    check("dir", 32'(o_dir), 32'(e_dir));
    check("sync_cnt", 32'(o_sync_cnt), 32'(e_cnt));
    check("quad_err", 32'(o_quad_err), 32'(e_qerr));
    check("overrun", 32'(o_overrun), 32'(e_ovr));
    if (rst_n) begin
      d     = (gidx(q2[2:1]) - gidx(q3[2:1]) + 4) % 4;
      fwd   = (d == 1);
      bwd   = (d == 3);
      ill   = (d == 2);
      srise = q2[0] & ~q3[0];
      chg   = (i_mode != m_mode_q);
      div   = (i_wheel_div == 8'd0) ? 1 : int'(i_wheel_div);
      trig  = 1'b0;
      case (i_mode)
        2'b01:   trig = !chg && (i_period != 0) && (m_tcnt >= int'(i_period) - 1);
        2'b10:   trig = fwd && (m_acc + 1 >= div);
        2'b11:   trig = srise;
        default: trig = 1'b0;
      endcase
      if (chg) m_tcnt = 0;
      else if (i_mode == 2'b01 && i_period != 0)
        m_tcnt = (m_tcnt >= int'(i_period) - 1) ? 0 : m_tcnt + 1;
      if (chg) m_acc = 0;
      else if (i_mode == 2'b10) begin
        if (fwd) m_acc = (m_acc + 1 >= div) ? 0 : m_acc + 1;
        else if (bwd && m_acc > -255) m_acc = m_acc - 1;
      end
      busy = (cyc <= m_last + PW + GAP);
      if (trig && !busy) begin
        m_last = cyc;
        e_cnt  = e_cnt + 16'd1;
      end
      e_msync_n = !((cyc + 1 > m_last) && (cyc + 1 <= m_last + PW));
      if (ill) e_qerr = 1'b1; else if (i_err_clr) e_qerr = 1'b0;
      if (trig && busy) e_ovr = 1'b1; else if (i_err_clr) e_ovr = 1'b0;
      if (fwd) begin e_pos = e_pos + 32'd1; e_dir = 1'b1; end
      if (bwd) begin e_pos = e_pos - 32'd1; e_dir = 1'b0; end
      q3 = q2; q2 = q1; q1 = {i_adp, i_bdp, i_sync};
      m_mode_q = i_mode;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step_to(input logic [1:0] ab);
    {i_adp, i_bdp} = ab;
    tick(40);
  endtask

  initial begin
    int lows;
    int guard;
    tick(3);
    check("rst_msync_n", 32'(o_msync_n), 32'd1);
    check("rst_pos", o_wheel_pos, 32'd0);
    check("rst_dir", 32'(o_dir), 32'd1);
    check("rst_cnt", 32'(o_sync_cnt), 32'd0);
    check("rst_qerr", 32'(o_quad_err), 32'd0);
    check("rst_ovr", 32'(o_overrun), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Internal timer, period 1000
    i_mode = 2'b01; i_period = 24'd1000;
    tick(5010);
    check("timer_cnt", 32'(o_sync_cnt), 32'd5);
    check("timer_ovr", 32'(o_overrun), 32'd0);
    i_mode = 2'b00;
    tick(150);

    // Wheel, div 4: 8 forward steps, then 2 back and 2 forward
    i_mode = 2'b10; i_wheel_div = 8'd4;
    tick(5);
    step_to(2'b01); step_to(2'b11); step_to(2'b10); step_to(2'b00);
    step_to(2'b01); step_to(2'b11); step_to(2'b10); step_to(2'b00);
    check("wheel_cnt", 32'(o_sync_cnt), 32'd7);
    check("wheel_pos8", o_wheel_pos, 32'd8);
    check("wheel_dir_f", 32'(o_dir), 32'd1);
    step_to(2'b10); step_to(2'b11);
    check("wheel_pos6", o_wheel_pos, 32'd6);
    check("wheel_dir_b", 32'(o_dir), 32'd0);
    step_to(2'b10); step_to(2'b00);
    check("wheel_pos_back", o_wheel_pos, 32'd8);
    check("wheel_no_retrig", 32'(o_sync_cnt), 32'd7);

    // Illegal quadrature transition and error clear
    {i_adp, i_bdp} = 2'b11;
    tick(10);
    check("qerr_set", 32'(o_quad_err), 32'd1);
    check("qerr_pos", o_wheel_pos, 32'd8);
    i_err_clr = 1'b1; tick(1); i_err_clr = 1'b0; tick(1);
    check("qerr_clr", 32'(o_quad_err), 32'd0);
    step_to(2'b10); step_to(2'b00);

    // External sync: accepted edge, then an edge inside the hold-off
    i_mode = 2'b11;
    tick(5);
    i_sync = 1'b1;
    tick(2);
    check("ext_before", 32'(o_msync_n), 32'd1);
    tick(1);
    check("ext_low", 32'(o_msync_n), 32'd0);
    lows = 0;
    for (int i = 0; i < 15; i++) begin
      if (!o_msync_n) lows++;
      tick(1);
    end
    check("ext_width", 32'(lows), 32'd10);
    i_sync = 1'b0;
    tick(32);
    i_sync = 1'b1;
    tick(5);
    check("ext_ovr", 32'(o_overrun), 32'd1);
    check("ext_drop_cnt", 32'(o_sync_cnt), 32'd8);
    i_sync = 1'b0;
    tick(150);
    i_err_clr = 1'b1; tick(1); i_err_clr = 1'b0; tick(1);
    check("ovr_clr", 32'(o_overrun), 32'd0);

    // Timer with period 0 never fires; a mode switch mid-pulse lets it finish
    i_mode = 2'b01; i_period = 24'd0;
    tick(10000);
    check("per0_cnt", 32'(o_sync_cnt), 32'd8);
    i_period = 24'd150;
    guard = 0;
    while (o_msync_n && guard < 400) begin tick(1); guard++; end
    check("per150_timeout", 32'(guard < 400), 32'd1);
    i_mode = 2'b00;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      if (!o_msync_n) lows++;
      tick(1);
    end
    check("modeoff_width", 32'(lows), 32'd10);
    check("modeoff_cnt", 32'(o_sync_cnt), 32'd9);

    // Asynchronous reset in the middle of a pulse
    i_mode = 2'b01;
    guard = 0;
    while (o_msync_n && guard < 400) begin tick(1); guard++; end
    check("rst_pulse_timeout", 32'(guard < 400), 32'd1);
    tick(3);
    check("pre_rst_low", 32'(o_msync_n), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_msync_n", 32'(o_msync_n), 32'd1);
    check("async_cnt", 32'(o_sync_cnt), 32'd0);
    i_mode = 2'b00;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check("post_cnt", 32'(o_sync_cnt), 32'd0);
    check("post_pos", o_wheel_pos, 32'd0);
    check("post_dir", 32'(o_dir), 32'd1);
    check("post_msync_n", 32'(o_msync_n), 32'd1);
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
